// File: rtl/bsg_idiv_arb_pkg.sv
// ============================================================================
// Module  : bsg_idiv_arb_pkg
// Brief   : Shared types and helpers for the divider-sharing arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bsg_idiv_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DIVZ  = 2'd3
  } state_e;

  // Pointer to the requester just after the winner, wrapping N-1 -> 0.
  function automatic int unsigned rr_next_ptr(input int unsigned id, input int unsigned n);
    return (id + 1 >= n) ? 0 : id + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_idiv_arb_rr.sv
// ============================================================================
// Module  : bsg_idiv_arb_rr
// Brief   : Round-robin picker: first valid index at or after the pointer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bsg_idiv_arb_rr #(
  parameter int  num_req_p   = 4,
  localparam int id_width_lp = $clog2(num_req_p)
) (
  input  logic [num_req_p-1:0]   i_valid,
  input  logic [id_width_lp-1:0] i_ptr,
  output logic [num_req_p-1:0]   o_grant,
  output logic [id_width_lp-1:0] o_grant_id
);

  logic [id_width_lp:0] w_idx;
  logic                 w_found;

  always_comb begin
    o_grant    = '0;
    o_grant_id = '0;
    w_found    = 1'b0;
    w_idx      = '0;
    for (int i = 0; i < num_req_p; i++) begin
      // ptr + i stays below 2N, so one conditional subtract is the modulo.
      w_idx = {1'b0, i_ptr} + (id_width_lp+1)'(i);
      if (w_idx >= (id_width_lp+1)'(num_req_p))
        w_idx = w_idx - (id_width_lp+1)'(num_req_p);
      if (!w_found && i_valid[w_idx[id_width_lp-1:0]]) begin
        o_grant[w_idx[id_width_lp-1:0]] = 1'b1;
        o_grant_id                      = w_idx[id_width_lp-1:0];
        w_found                         = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bsg_idiv_share_arbiter.sv
// ============================================================================
// Module  : bsg_idiv_share_arbiter
// Brief   : Shares one iterative divider among num_req_p requesters, round-robin,
//           one division in flight. Optional macro BSG_IDIV_ARB_DIVZ_BYPASS_EN
//           answers zero-divisor requests locally without using the divider.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bsg_idiv_share_arbiter
  import bsg_idiv_arb_pkg::*;
#(
  parameter int  num_req_p   = 4,
  parameter int  width_p     = 64,
  localparam int id_width_lp = $clog2(num_req_p)
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic [num_req_p-1:0]           req_v_i,
  output logic [num_req_p-1:0]           req_ready_and_o,
  input  logic [num_req_p*width_p-1:0]   req_dividend_i,
  input  logic [num_req_p*width_p-1:0]   req_divisor_i,
  input  logic [num_req_p-1:0]           req_signed_i,
  output logic [num_req_p-1:0]           resp_v_o,
  output logic [width_p-1:0]             resp_quotient_o,
  output logic [width_p-1:0]             resp_remainder_o,
  input  logic [num_req_p-1:0]           resp_yumi_i,
  output logic                           div_v_o,
  input  logic                           div_ready_and_i,
  output logic [width_p-1:0]             div_dividend_o,
  output logic [width_p-1:0]             div_divisor_o,
  output logic                           div_signed_o,
  input  logic                           div_v_i,
  output logic                           div_yumi_o,
  input  logic [width_p-1:0]             div_quotient_i,
  input  logic [width_p-1:0]             div_remainder_i
);

  typedef struct packed {
    logic               sign;
    logic [width_p-1:0] dividend;
    logic [width_p-1:0] divisor;
  } op_rec_t;

  state_e                 r_state;
  logic [id_width_lp-1:0] r_rr_ptr;
  logic [id_width_lp-1:0] r_owner;
  op_rec_t                r_op;

  logic [num_req_p-1:0]   w_grant;
  logic [id_width_lp-1:0] w_grant_id;
  logic                   w_any_req;
  op_rec_t                w_win_op;
  logic                   w_div_yumi;

  bsg_idiv_arb_rr #(
    .num_req_p (num_req_p)
  ) u_rr (
    .i_valid    (req_v_i),
    .i_ptr      (r_rr_ptr),
    .o_grant    (w_grant),
    .o_grant_id (w_grant_id)
  );

  assign w_any_req = |req_v_i;

  always_comb begin
    w_win_op          = '0;
    w_win_op.sign     = req_signed_i[w_grant_id];
    w_win_op.dividend = req_dividend_i[int'(w_grant_id)*width_p +: width_p];
    w_win_op.divisor  = req_divisor_i[int'(w_grant_id)*width_p +: width_p];
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_op     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_op     <= w_win_op;
            r_owner  <= w_grant_id;
            r_rr_ptr <= id_width_lp'(rr_next_ptr(32'(w_grant_id), 32'(num_req_p)));
`ifdef BSG_IDIV_ARB_DIVZ_BYPASS_EN
            r_state  <= (w_win_op.divisor == '0) ? ST_DIVZ : ST_ISSUE;
`else
            r_state  <= ST_ISSUE;
`endif
          end
        end
        ST_ISSUE: if (div_ready_and_i) r_state <= ST_BUSY;
        ST_BUSY:  if (w_div_yumi)      r_state <= ST_IDLE;
`ifdef BSG_IDIV_ARB_DIVZ_BYPASS_EN
        ST_DIVZ:  if (resp_yumi_i[r_owner]) r_state <= ST_IDLE;
`endif
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Handshake outputs are forced low during reset regardless of the old state.
  always_comb begin
    req_ready_and_o  = '0;
    div_v_o          = 1'b0;
    resp_v_o         = '0;
    resp_quotient_o  = '0;
    resp_remainder_o = '0;
    w_div_yumi       = 1'b0;
    if (reset_n_i) begin
      case (r_state)
        ST_IDLE:  req_ready_and_o = w_grant;
        ST_ISSUE: div_v_o = 1'b1;
        ST_BUSY: begin
          resp_v_o[r_owner] = div_v_i;
          if (div_v_i) begin
            resp_quotient_o  = div_quotient_i;
            resp_remainder_o = div_remainder_i;
          end
          w_div_yumi = div_v_i & resp_yumi_i[r_owner];
        end
`ifdef BSG_IDIV_ARB_DIVZ_BYPASS_EN
        ST_DIVZ: begin
          resp_v_o[r_owner] = 1'b1;
          resp_quotient_o   = '1;
          resp_remainder_o  = r_op.dividend;
        end
`endif
        default: ;
      endcase
    end
  end

  assign div_yumi_o     = w_div_yumi;
  assign div_dividend_o = r_op.dividend;
  assign div_divisor_o  = r_op.divisor;
  assign div_signed_o   = r_op.sign;

endmodule

`default_nettype wire
